// File: rtl/btn_pkg.sv
// btn_pkg: shared types and default constants for the push-button event controller.
//   btn_state_t    : FSM state encoding (IDLE, PRESSED, HELD)
//   BTN_CNT_W      : width of the hold counter
//   BTN_LONG_CYC   : default long-press threshold in clocks (500 ms at 24 MHz)
//   BTN_REPEAT_CYC : default auto-repeat period in clocks (100 ms at 24 MHz)
package btn_pkg;

   localparam int unsigned BTN_CNT_W      = 24;
   localparam int unsigned BTN_LONG_CYC   = 12_000_000;
   localparam int unsigned BTN_REPEAT_CYC = 2_400_000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } btn_state_t;

endpackage

// File: rtl/btn_event_ctrl_if.sv
// btn_event_ctrl_if: button level in, classified events and index registers out.
//   IntBTN     : debounced button level, active-low (idle 1)
//   ShortPress : one-cycle pulse on release before the long-press threshold
//   LongPress  : one-cycle pulse when the hold reaches the long-press threshold
//   Repeat     : one-cycle pulse per repeat period while held after a long press
//   WaveSel    : waveform select, wraps modulo 4
//   FreqIdx    : frequency-step index, saturating
// Modports: master = event controller, slave = button source / event consumer.
interface btn_event_ctrl_if;

   logic       IntBTN;
   logic       ShortPress;
   logic       LongPress;
   logic       Repeat;
   logic [1:0] WaveSel;
   logic [3:0] FreqIdx;

   modport master (
      input  IntBTN,
      output ShortPress, LongPress, Repeat, WaveSel, FreqIdx
   );

   modport slave (
      output IntBTN,
      input  ShortPress, LongPress, Repeat, WaveSel, FreqIdx
   );

endinterface

// File: rtl/btn_hold_timer.sv
// btn_hold_timer: hold-interval counter shared by long-press and repeat timing.
//   Fg_CLK, RESET : clock, asynchronous active-high reset
//   clear         : force count to 0 (takes priority over enable)
//   enable        : advance count; wraps to 0 on the cycle it hits terminal
//   terminal      : terminal count (interval length minus one)
//   hit           : count currently equals terminal
module btn_hold_timer
   import btn_pkg::*;
(
   input  logic                 Fg_CLK,
   input  logic                 RESET,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [BTN_CNT_W-1:0] terminal,
   output logic                 hit
);

   logic [BTN_CNT_W-1:0] cnt;

   assign hit = (cnt == terminal);

   // Counter restarts at 0 after a hit so back-to-back intervals are exact.
   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= hit ? '0 : cnt + BTN_CNT_W'(1);
      end
   end

endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: classifies debounced button presses into short/long/repeat events
// and maintains the WaveSel and FreqIdx index registers.
//   Fg_CLK : 24 MHz system clock
//   RESET  : asynchronous active-high reset
//   btn    : btn_event_ctrl_if.master (IntBTN in; pulses and indices out, registered)
// Optional feature: define BTN_AUTOREPEAT_EN to enable auto-repeat while held.
module btn_event_ctrl
   import btn_pkg::*;
#(
   parameter int unsigned LONG_CYC   = BTN_LONG_CYC,
   parameter int unsigned REPEAT_CYC = BTN_REPEAT_CYC,
   parameter int unsigned STEP_MAX   = 15
) (
   input  logic              Fg_CLK,
   input  logic              RESET,
   btn_event_ctrl_if.master  btn
);

   localparam logic [BTN_CNT_W-1:0] LONG_TERM = BTN_CNT_W'(LONG_CYC - 1);
   localparam logic [BTN_CNT_W-1:0] REP_TERM  = BTN_CNT_W'(REPEAT_CYC - 1);
   localparam logic [3:0]           STEP_TOP  = 4'(STEP_MAX);

   btn_state_t           state, state_nxt;
   logic                 prev;
   logic                 short_c, long_c, rep_c;
   logic                 tmr_clear, tmr_en, tmr_hit;
   logic [BTN_CNT_W-1:0] tmr_term;
   logic                 short_q, long_q, rep_q;
   logic [1:0]           wave_q;
   logic [3:0]           freq_q;

   btn_hold_timer u_timer (
      .Fg_CLK   (Fg_CLK),
      .RESET    (RESET),
      .clear    (tmr_clear),
      .enable   (tmr_en),
      .terminal (tmr_term),
      .hit      (tmr_hit)
   );

   // State register; prev resets to 0 so a button held through reset is ignored.
   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         prev  <= 1'b0;
      end else begin
         state <= state_nxt;
         prev  <= btn.IntBTN;
      end
   end

   // Next-state and event decode; release always wins over a same-cycle timer hit.
   always_comb begin
      state_nxt = state;
      short_c   = 1'b0;
      long_c    = 1'b0;
      rep_c     = 1'b0;
      tmr_clear = 1'b1;
      tmr_en    = 1'b0;
      tmr_term  = LONG_TERM;
      case (state)
         IDLE: begin
            if (prev && !btn.IntBTN) state_nxt = PRESSED;
         end
         PRESSED: begin
            if (btn.IntBTN) begin
               short_c   = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmr_clear = 1'b0;
               tmr_en    = 1'b1;
               if (tmr_hit) begin
                  long_c    = 1'b1;
                  state_nxt = HELD;
               end
            end
         end
         HELD: begin
            tmr_term = REP_TERM;
            if (btn.IntBTN) begin
               state_nxt = IDLE;
            end else begin
`ifdef BTN_AUTOREPEAT_EN
               tmr_clear = 1'b0;
               tmr_en    = 1'b1;
               if (tmr_hit) rep_c = 1'b1;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered pulses; index registers move on the same edge as their pulse.
   always_ff @(posedge Fg_CLK or posedge RESET) begin
      if (RESET) begin
         short_q <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
         wave_q  <= '0;
         freq_q  <= '0;
      end else begin
         short_q <= short_c;
         long_q  <= long_c;
         rep_q   <= rep_c;
         if (short_c) wave_q <= wave_q + 2'd1;
         if ((long_c || rep_c) && (freq_q < STEP_TOP)) freq_q <= freq_q + 4'd1;
      end
   end

   assign btn.ShortPress = short_q;
   assign btn.LongPress  = long_q;
   assign btn.Repeat     = rep_q;
   assign btn.WaveSel    = wave_q;
   assign btn.FreqIdx    = freq_q;

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Downstream consumer of the debounced push-button level (`IntBTN`) that turns each press into classified user events for the DDS front panel. Short presses step the waveform select; long presses and auto-repeat while held step the frequency-increment index. Outputs are registered single-cycle pulses plus two index registers, all in the `Fg_CLK` (24 MHz) domain.

## Interface
- `LONG_CYC`, default 12_000_000: hold duration in clocks before a long press is declared (500 ms at 24 MHz).
- `REPEAT_CYC`, default 2_400_000: auto-repeat period in clocks while held after a long press (100 ms).
- `STEP_MAX`, default 15: maximum value of `FreqIdx`; must be ≤ 15.
- `Fg_CLK`, input, 1: system clock. The block uses this one clock only.
- `RESET`, input, 1: asynchronous, active-high reset.
- `IntBTN`, input, 1: debounced button level, active-low (idle 1). It is already synchronous to `Fg_CLK`.
- `ShortPress`, output, 1: one-cycle pulse on a release before `LONG_CYC`.
- `LongPress`, output, 1: one-cycle pulse when the hold reaches `LONG_CYC`.
- `Repeat`, output, 1: one-cycle pulse every `REPEAT_CYC` while held after a long press.
- `WaveSel`, output, 2: waveform select. Increments modulo 4 on each `ShortPress`.
- `FreqIdx`, output, 4: frequency-step index. Increments on `LongPress` or `Repeat` and saturates at `STEP_MAX`.

## Operation
- `prev` register holds the `IntBTN` value from the previous cycle. A press edge is defined as `prev`=1 and `IntBTN`=0.
- State machine with three states: IDLE, PRESSED and HELD. The hold counter `cnt` is 24 bits wide.
- **IDLE:** `cnt`=0. On a press edge, move to PRESSED with `cnt`=0.
- **PRESSED:**
  - If `IntBTN`=1, pulse `ShortPress` and move to IDLE.
  - Else if `cnt`==`LONG_CYC`-1, pulse `LongPress`, move to HELD and set `cnt`=0.
  - Else `cnt`++.
- **HELD:**
  - If `IntBTN`=1, move to IDLE with no pulse.
  - Else if `cnt`==`REPEAT_CYC`-1, pulse `Repeat` and set `cnt`=0.
  - Else `cnt`++.
- `WaveSel` wraps from 3 to 0.
- `FreqIdx` holds at `STEP_MAX`. Pulses still fire when `FreqIdx` is saturated.
- Reset values:
  - State = IDLE, `cnt`=0.
  - `prev`=0, so a button held through reset produces no event until it is released and pressed again.
  - All pulse outputs 0, `WaveSel`=0, `FreqIdx`=0.
- Reset mid-press aborts the press and emits no pulse.

## Timing
- t0 is the clock edge that samples the press edge.
- `LongPress` is high during the cycle after edge t0+`LONG_CYC`.
- `Repeat` pulses follow every `REPEAT_CYC` clocks after that.
- `ShortPress` is high in the cycle after the edge that first samples `IntBTN`=1.
- Release sampled on the same edge where `cnt`==`LONG_CYC`-1 counts as a short press; release has priority.
- Index registers update on the same edge that raises the corresponding pulse. The new value is visible together with the pulse.
- Pulses never overlap. At most one event occurs per cycle.
- Minimum press-to-press spacing: a new press edge is accepted on the cycle immediately after returning to IDLE.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: HELD generates `Repeat` as above.
- Not defined:
  - HELD only waits for release and `cnt` is frozen at 0.
  - `Repeat` is tied to 0.
  - `FreqIdx` advances only on `LongPress`.
  - `REPEAT_CYC` is ignored.

## Structure
- Package `btn_pkg` holds:
  - State enum `btn_state_t` (IDLE, PRESSED, HELD).
  - Default constants `BTN_LONG_CYC` and `BTN_REPEAT_CYC`.
  - `BTN_CNT_W`=24.
- One sub-module, `btn_hold_timer`:
  - Inputs: `clear`, `enable`, terminal count.
  - Output: `hit`.
  - Used for both long-press and repeat intervals.
- Top-level `btn_event_ctrl` contains the FSM, edge detect and index registers.

## Test plan
All scenarios use `LONG_CYC`=100, `REPEAT_CYC`=20, `STEP_MAX`=3.
- **Short press:** hold `IntBTN` low for 40 clocks, then release → one `ShortPress` pulse, `WaveSel` 0→1, no `LongPress`, `FreqIdx`=0.
- **Long press with repeat:** hold low 165 clocks → `LongPress` at t0+100, `Repeat` at t0+120, +140, +160, `FreqIdx` saturates at 3. Release produces no `ShortPress`.
- **Boundary:** release on the sample where `cnt`=99 → `ShortPress` only. Release one cycle later → `LongPress` only.
- **WaveSel wrap:** five short presses → `WaveSel` sequence 1, 2, 3, 0, 1.
- **Reset mid-press:** assert `RESET` at cnt=50 while held, deassert while still low → no pulses until release and re-press. The re-press then behaves normally.
- **Without `BTN_AUTOREPEAT_EN`:** hold 165 clocks → exactly one `LongPress`, `Repeat` stays 0, `FreqIdx`=1.
